// File: rtl/pft_banked_buffer.sv
// pft_banked_buffer: banked feature buffer, per-bank read addresses, shared write port, masked/centroid reads, init sweep.
// Latency is three registers: RAM read register, stage 1 (RAM outputs plus mask/mode), stage 2 (lane mux plus priority encode).
module pft_banked_buffer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int PE_COL = 16,
  parameter int NUM_BANK = 32,
  parameter logic [DATA_W-1:0] PAD_VAL = {1'b1, {DATA_W-1{1'b0}}},
  localparam int CB_W = $clog2(NUM_BANK)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_BANK-1:0]                 wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W*PE_COL-1:0]            wr_data_i,
  input  logic                                rd_req_i,
  input  logic [ADDR_W*NUM_BANK-1:0]          rd_addr_i,
  input  logic [NUM_BANK-1:0]                 rd_mask_i,
  input  logic                                rd_centroid_i,
  input  logic                                init_start_i,
  output logic                                init_busy_o,
  output logic                                out_valid_o,
  output logic [CB_W-1:0]                     out_cbank_o,
  output logic                                centroid_none_o,
  output logic [NUM_BANK*PE_COL*DATA_W-1:0]   dout_o
);
  localparam int WW = DATA_W*PE_COL;
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, INIT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0] mem [NUM_BANK][DEPTH];
  logic [WW-1:0] ram_q [NUM_BANK];
  logic [WW-1:0] word_q [NUM_BANK];
  logic v0_q, v1_q, c0_q, c1_q;
  logic [NUM_BANK-1:0] m0_q, m1_q;
  logic [CB_W-1:0] pri_cb;
  logic pri_none;
  logic [NUM_BANK*WW-1:0] dout_d;

  assign init_busy_o = state_q == INIT;

  always_comb begin
    state_d = init_busy_o ? (&cnt_q ? IDLE : INIT) : (init_start_i ? INIT : IDLE);
    cnt_d = init_busy_o ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Nonblocking RAM read register gives read-first behaviour against same-edge writes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (init_busy_o) mem[b][cnt_q] <= {PE_COL{PAD_VAL}};
      else if (wr_en_i[b]) mem[b][wr_addr_i] <= wr_data_i;
      ram_q[b] <= mem[b][rd_addr_i[b*ADDR_W +: ADDR_W]];
      word_q[b] <= ram_q[b];
    end
  end

  always_comb begin
    pri_cb = '0;
    pri_none = 1'b1;
    for (int b = NUM_BANK-1; b >= 0; b--) begin
      if (m1_q[b]) begin
        pri_cb = CB_W'(b);
        pri_none = 1'b0;
      end
    end
    dout_d = '0;
    for (int b = 0; b < NUM_BANK; b++)
      for (int c = 0; c < PE_COL; c++)
        dout_d[(c*NUM_BANK+b)*DATA_W +: DATA_W] = m1_q[b] ? word_q[b][c*DATA_W +: DATA_W] : PAD_VAL;
    if (c1_q) begin
      dout_d = '0;
      dout_d[WW-1:0] = pri_none ? {PE_COL{PAD_VAL}} : word_q[pri_cb];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
      m0_q <= '0;
      m1_q <= '0;
      out_valid_o <= 1'b0;
      out_cbank_o <= '0;
      centroid_none_o <= 1'b0;
      dout_o <= '0;
    end else begin
      v0_q <= rd_req_i & ~init_busy_o;
      c0_q <= rd_centroid_i;
      m0_q <= rd_mask_i;
      v1_q <= v0_q;
      c1_q <= c0_q;
      m1_q <= m0_q;
      out_valid_o <= v1_q;
      if (v1_q) begin
        dout_o <= dout_d;
        out_cbank_o <= c1_q ? pri_cb : '0;
        centroid_none_o <= c1_q & pri_none;
      end
    end
  end
endmodule

// File: tb/tb_pft_banked_buffer.sv
// tb_pft_banked_buffer: random and directed stimulus against a word-level reference model, plus a small-geometry instance.
module tb_pft_banked_buffer;
  localparam int NB = 32, PC = 16, DW = 8, AW = 5, WW = 128, OW = 4096;
  localparam logic [7:0] PAD = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0] wr_en, rd_mask;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [AW*NB-1:0] rd_addr;
  logic rd_req, rd_cent, init_start;
  logic busy, ov, cnone;
  logic [4:0] cbank;
  logic [OW-1:0] dout;

  logic [7:0] s_wr_en, s_rd_mask;
  logic [2:0] s_wr_addr;
  logic [31:0] s_wr_data;
  logic [23:0] s_rd_addr;
  logic s_rd_req, s_rd_cent, s_init;
  logic s_busy, s_ov, s_none;
  logic [2:0] s_cbank;
  logic [255:0] s_dout;

  int nchk = 0, nerr = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  pft_banked_buffer #(.ADDR_W(AW), .DATA_W(DW), .PE_COL(PC), .NUM_BANK(NB)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_mask_i(rd_mask), .rd_centroid_i(rd_cent),
    .init_start_i(init_start), .init_busy_o(busy), .out_valid_o(ov), .out_cbank_o(cbank),
    .centroid_none_o(cnone), .dout_o(dout));

  pft_banked_buffer #(.ADDR_W(3), .DATA_W(8), .PE_COL(4), .NUM_BANK(8)) u_small (
    .clk(clk), .rst_n(rst_n), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .rd_req_i(s_rd_req), .rd_addr_i(s_rd_addr), .rd_mask_i(s_rd_mask), .rd_centroid_i(s_rd_cent),
    .init_start_i(s_init), .init_busy_o(s_busy), .out_valid_o(s_ov), .out_cbank_o(s_cbank),
    .centroid_none_o(s_none), .dout_o(s_dout));

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    int i;
    i = 0;
    nchk++;
    if (act !== exp) begin
      nerr++;
      while (i < 63 && act[i*64 +: 64] === exp[i*64 +: 64]) i++;
      $display("FAIL %s: got %h expected %h (64-bit word %0d)", nm, act[i*64 +: 64], exp[i*64 +: 64], i);
    end
  endtask

  // Reference model: word-level memory, accepted reads evaluated at acceptance, 3-edge delay line.
  logic [WW-1:0] mm [NB][2**AW];
  logic pv0 = 0, pv1 = 0, pn0 = 0, pn1 = 0, hv = 0, hn = 0;
  logic [4:0] pcb0 = 0, pcb1 = 0, hcb = 0;
  logic [OW-1:0] pd0 = '0, pd1 = '0, hd = '0;
  int mcnt = 0, mi = 0;

  function automatic logic [OW-1:0] model_read(input logic [AW*NB-1:0] a, input logic [NB-1:0] m,
                                               input logic cent, output logic [4:0] cb, output logic nn);
    logic [OW-1:0] r;
    logic [NB-1:0] low;
    r = '0;
    cb = 0;
    nn = 0;
    if (cent) begin
      low = m & (~m + 1'b1);
      nn = (m == 0);
      cb = nn ? 5'd0 : 5'($clog2(low));
      r[WW-1:0] = nn ? {PC{PAD}} : mm[cb][a[cb*AW +: AW]];
    end else begin
      for (int b = 0; b < NB; b++)
        for (int c = 0; c < PC; c++)
          r[(c*NB+b)*DW +: DW] = m[b] ? mm[b][a[b*AW +: AW]][c*DW +: DW] : PAD;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv0 = 0; pv1 = 0; hv = 0; hd = '0; hcb = 0; hn = 0; mcnt = 0;
    end else begin
      hv = pv1;
      if (pv1) begin hd = pd1; hcb = pcb1; hn = pn1; end
      pv1 = pv0; pd1 = pd0; pcb1 = pcb0; pn1 = pn0;
      pv0 = rd_req && mcnt == 0;
      if (pv0) pd0 = model_read(rd_addr, rd_mask, rd_cent, pcb0, pn0);
      if (mcnt > 0) begin
        for (int b = 0; b < NB; b++) mm[b][mi] = {PC{PAD}};
        mi++;
        mcnt--;
      end else begin
        for (int b = 0; b < NB; b++) if (wr_en[b]) mm[b][wr_addr] = wr_data;
        if (init_start) begin mcnt = 2**AW; mi = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("init_busy", busy, mcnt > 0);
      chk("out_valid", ov, hv);
      chk("dout", dout, hd);
      chk("out_cbank", cbank, hcb);
      chk("centroid_none", cnone, hn);
    end
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0; rd_mask = '0; rd_cent = 0; init_start = 0;
    s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0; s_rd_req = 0; s_rd_addr = '0; s_rd_mask = '0; s_rd_cent = 0; s_init = 0;
  endtask

  task automatic wr(input logic [NB-1:0] en, input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_en = en; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic cent);
    rd_req = 1; rd_addr = {NB{a}}; rd_mask = m; rd_cent = cent;
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic wait_out(input bit sm);
    int k;
    k = 0;
    while (!(sm ? s_ov : ov) && k < 8) begin @(negedge clk); k++; end
    chk("valid_timeout", sm ? s_ov : ov, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk("busy_timeout", busy, 0);
  endtask

  initial begin
    logic [OW-1:0] e;
    logic [255:0] es;
    int n, nv;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_valid", ov, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cbank", cbank, 0);
    chk("rst_none", cnone, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    chk_on = 1;
    init_start = 1;
    @(negedge clk);
    init_start = 0;
    n = 0; nv = 0;
    while (busy && n < 100) begin
      n++; nv += int'(ov);
      wr_en = $urandom; wr_addr = AW'($urandom); wr_data = {4{$urandom}};
      rd_req = 1; rd_addr = {5{$urandom}}; rd_mask = '1; init_start = $urandom_range(0, 1);
      @(negedge clk);
    end
    idle();
    repeat (3) begin nv += int'(ov); @(negedge clk); end
    chk("init_cycles", n, 32);
    chk("init_drop_valid", nv, 0);

    wr(32'h0000_0008, 5'd5, 128'h0F0E0D0C0B0A09080706050403020100);
    rd(5'd5, 32'h0000_0008, 0);
    wait_out(0);
    e = {512{PAD}};
    for (int c = 0; c < PC; c++) e[(c*NB+3)*DW +: DW] = 8'(c);
    chk("full_dout", dout, e);
    chk("full_cbank", cbank, 0);
    @(negedge clk);

    wr(32'h0000_0020, 5'd5, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    wr(32'h0000_0400, 5'd5, 128'h5555);
    rd(5'd5, 32'h0000_0420, 1);
    wait_out(0);
    chk("cent_cbank", cbank, 5);
    chk("cent_none", cnone, 0);
    chk("cent_dout", dout, {3968'b0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D});
    @(negedge clk);
    rd(5'd5, 32'h0, 1);
    wait_out(0);
    chk("empty_none", cnone, 1);
    chk("empty_cbank", cbank, 0);
    chk("empty_dout", dout, {3968'b0, {16{PAD}}});
    @(negedge clk);

    wr_en = 32'h8; wr_addr = 5'd5; wr_data = {8{16'h1111}};
    rd(5'd5, 32'h0000_0008, 0);
    wr_en = '0;
    wait_out(0);
    chk("rdw_old_data", dout, e);
    @(negedge clk);

    nv = 0;
    for (int i = 0; i < 10; i++) begin
      nv += int'(ov);
      rd_req = i < 4; rd_addr = {NB{AW'(i)}}; rd_mask = 32'h0000_00FF << i; rd_cent = 0;
      @(negedge clk);
    end
    idle();
    chk("b2b_count", nv, 4);

    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_req = $urandom_range(0, 3) != 0;
      for (int b = 0; b < NB; b++) rd_addr[b*AW +: AW] = AW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rd_mask = $urandom;
        1: rd_mask = '0;
        2: rd_mask = 32'(1) << $urandom_range(0, 31);
        default: rd_mask = '1;
      endcase
      rd_cent = $urandom_range(0, 1);
      init_start = $urandom_range(0, 499) == 0;
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    wait_idle();
    init_start = 1;
    @(negedge clk);
    init_start = 0;
    @(negedge clk);
    wait_idle();
    rd(AW'($urandom), '1, 0);
    wait_out(0);
    chk("post_init_pad", dout, {512{PAD}});
    @(negedge clk);

    rd(5'd5, 32'h0000_0008, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", ov, 0);
    chk("rst_mid_dout", dout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    nv = 0;
    repeat (5) begin @(negedge clk); nv += int'(ov); end
    chk("rst_no_stale", nv, 0);

    s_wr_en = 8'h04; s_wr_addr = 3'd3; s_wr_data = 32'hA1B2C3D4;
    @(negedge clk);
    s_wr_en = 8'h40; s_wr_data = 32'h11223344;
    @(negedge clk);
    s_wr_en = '0;
    s_rd_req = 1; s_rd_addr = {8{3'd3}}; s_rd_mask = 8'h04; s_rd_cent = 0;
    @(negedge clk);
    s_rd_req = 0;
    wait_out(1);
    es = {32{PAD}};
    es[(0*8+2)*8 +: 8] = 8'hD4;
    es[(1*8+2)*8 +: 8] = 8'hC3;
    es[(2*8+2)*8 +: 8] = 8'hB2;
    es[(3*8+2)*8 +: 8] = 8'hA1;
    chk("small_full_dout", s_dout, es);
    chk("small_full_cbank", s_cbank, 0);
    @(negedge clk);
    s_rd_req = 1; s_rd_mask = 8'hC0; s_rd_cent = 1;
    @(negedge clk);
    s_rd_req = 0;
    wait_out(1);
    chk("small_cent_cbank", s_cbank, 6);
    chk("small_cent_none", s_none, 0);
    chk("small_cent_dout", s_dout, {224'b0, 32'h11223344});
    @(negedge clk);
    s_rd_req = 1; s_rd_mask = 8'h80;
    @(negedge clk);
    s_rd_req = 0;
    wait_out(1);
    chk("small_cent_top", s_cbank, 7);
    repeat (3) @(negedge clk);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
